spi_slave_rx: RTL and testbench

//  SPI mode-0 slave for the alarm-system link. MSB first, DATA_W-bit words, several words allowed per SS_n-low frame.

---
 rtl/spi_slave_rx_pkg.sv | 15 +
 rtl/spi_slave_rx_if.sv | 32 +++
 rtl/spi_slave_rx_sync_edge.sv | 42 ++++
 rtl/spi_slave_rx.sv | 139 +++++++++++++
 tb/tb_spi_slave_rx.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_rx_pkg.sv
// Shared types and constants for the SPI mode-0 receive slave.
package spi_slave_rx_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  // CPOL=0, CPHA=0: MOSI sampled on SCLK rise, MISO changed on SCLK fall.
  localparam int SPI_MODE        = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Pad and local-side signal bundle of the SPI receive slave.
//
// Handshake: rx_valid=1 means rx_data holds a word not yet taken. The consumer
// takes it in any cycle where rx_ack=1 and rx_valid=1; rx_valid drops on the
// next edge unless a new word completes in that same cycle. rx_ack with
// rx_valid=0 has no effect. There is no back-pressure on the SPI side: a word
// arriving while rx_valid=1 and no ack overwrites rx_data and sets overrun.
interface spi_slave_rx_if import spi_slave_rx_pkg::*; #(parameter int DATA_W = DATA_W_DEF);

  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_ss_n;
  logic              spi_miso;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              overrun;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  spi_sclk, spi_mosi, spi_ss_n, tx_data, rx_ack,
    output spi_miso, rx_data, rx_valid, overrun, frame_err, busy
  );

  modport master (
    output spi_sclk, spi_mosi, spi_ss_n, tx_data, rx_ack,
    input  spi_miso, rx_data, rx_valid, overrun, frame_err, busy
  );

endinterface

// File: rtl/spi_slave_rx_sync_edge.sv
// One pad synchroniser: STAGES flops, a history flop, registered edge strobes.
// o_level is the history flop so that level and strobes change on the same edge.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;
  logic              r_rise;
  logic              r_fall;
  logic              w_sync_out;

  assign w_sync_out = r_sync[STAGES-1];

  // Synchroniser chain, history flop and edge strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pad};
      r_hist <= w_sync_out;
      r_rise <= w_sync_out & ~r_hist;
      r_fall <= ~w_sync_out & r_hist;
    end
  end

  assign o_level = r_hist;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave, MSB first, multi-word frames, valid/ack word hand-off.
module spi_slave_rx import spi_slave_rx_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic   CLOCK_50,
  input  logic   rst,
  spi_slave_rx_if.slave bus,
  output state_t o_state
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic w_sclk_rise, w_sclk_fall;
  logic w_ss_lvl, w_ss_rise, w_ss_fall;
  logic w_mosi_lvl;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(CLOCK_50), .i_rst(rst), .i_pad(bus.spi_sclk),
    .o_level(), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
    .i_clk(CLOCK_50), .i_rst(rst), .i_pad(bus.spi_ss_n),
    .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(CLOCK_50), .i_rst(rst), .i_pad(bus.spi_mosi),
    .o_level(w_mosi_lvl), .o_rise(), .o_fall()
  );

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_W-2:0] r_rx_shift, w_rx_shift_nxt;
  // Holds the bits still to be driven, MSB first; the bit on MISO is already out.
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nxt;
  logic              r_miso, w_miso_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              r_overrun, w_overrun_nxt;
  logic              r_frame_err, w_frame_err_nxt;
  logic [DATA_W-1:0] w_word;

  // State register.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, shift registers, word hand-off and status flags.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_rx_shift_nxt  = r_rx_shift;
    w_tx_shift_nxt  = r_tx_shift;
    w_miso_nxt      = r_miso;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = r_rx_valid;
    w_overrun_nxt   = r_overrun;
    w_frame_err_nxt = 1'b0;
    w_word          = {r_rx_shift, w_mosi_lvl};

    if (r_rx_valid && bus.rx_ack) w_rx_valid_nxt = 1'b0;

    unique case (r_state)
      // Wait for a deselected bus so a frame is never joined halfway.
      ST_IDLE: begin
        if (w_ss_lvl) w_state_nxt = ST_IDLE == r_state ? ST_READY : r_state;
      end
      ST_READY: begin
        if (w_ss_fall) begin
          w_state_nxt    = ST_SHIFT;
          w_bit_cnt_nxt  = '0;
          w_miso_nxt     = bus.tx_data[DATA_W-1];
          w_tx_shift_nxt = {bus.tx_data[DATA_W-2:0], 1'b0};
        end
      end
      ST_SHIFT: begin
        if (w_ss_rise) begin
          // Deselect wins over a coincident SCLK rise.
          w_state_nxt     = ST_READY;
          w_frame_err_nxt = (r_bit_cnt != '0);
          w_bit_cnt_nxt   = '0;
          w_miso_nxt      = 1'b0;
        end else if (w_sclk_rise) begin
          w_rx_shift_nxt = w_word[DATA_W-2:0];
          if (r_bit_cnt == LAST_BIT) begin
            w_rx_data_nxt  = w_word;
            w_rx_valid_nxt = 1'b1;
            if (r_rx_valid && !bus.rx_ack) w_overrun_nxt = 1'b1;
            w_bit_cnt_nxt  = '0;
            // Full next word; its MSB goes out on the following SCLK fall.
            w_tx_shift_nxt = bus.tx_data;
          end else begin
            w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
          end
        end else if (w_sclk_fall) begin
          w_miso_nxt     = r_tx_shift[DATA_W-1];
          w_tx_shift_nxt = {r_tx_shift[DATA_W-2:0], 1'b0};
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_miso      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_miso      <= w_miso_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_overrun   <= w_overrun_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign bus.spi_miso  = r_miso;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state == ST_SHIFT);
  assign o_state       = r_state;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed vector table, corner sequences, random frames.
module tb_spi_slave_rx;
  import spi_slave_rx_pkg::*;

  localparam int HALF = 6;  // CLOCK_50 cycles per SCLK level (>= SYNC_STAGES+2)

  logic   clk;
  logic   rst;
  state_t dbg_state;

  spi_slave_rx_if #(.DATA_W(8)) bus();

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .CLOCK_50(clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, test incomplete");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  logic [7:0] exp_q[$];

  // frame_err pulses are counted in cycles high, sampled away from posedge.
  always @(negedge clk) if (bus.frame_err === 1'b1) fe_cnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_pads();
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_ss_n = 1'b1;
    bus.rx_ack   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_pads();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic m);
    bus.spi_mosi = b;
    repeat (HALF) @(negedge clk);
    bus.spi_sclk = 1'b1;
    m = bus.spi_miso;
    repeat (HALF) @(negedge clk);
    bus.spi_sclk = 1'b0;
  endtask

  // Sends one word MSB first and returns what MISO showed at each SCLK rise.
  // next_tx is presented before the final rise, where the slave samples it.
  task automatic send_word(input logic [7:0] w, input logic [7:0] next_tx,
                           input bit lat_chk, input bit ack_last,
                           output logic [7:0] mw);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = w[i];
      repeat (HALF) @(negedge clk);
      if (i == 0) bus.tx_data = next_tx;
      bus.spi_sclk = 1'b1;
      mw[i] = bus.spi_miso;
      if (i == 0 && (lat_chk || ack_last)) begin
        repeat (3) @(negedge clk);
        if (lat_chk) check("latency_before", bus.rx_valid, 1'b0);
        if (ack_last) bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        if (lat_chk) check("latency_at", bus.rx_valid, 1'b1);
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    bus.spi_ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    bus.spi_ss_n = 1'b1;
    repeat (HALF + 2) @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (bus.rx_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, bus.rx_valid, 1'b1);
  endtask

  task automatic ack_word(input string nm);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    check(nm, bus.rx_valid, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] mw;
    logic       mb;
    int         fe0;

    vecs[0] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{8'h80, 8'h01, 8'h80, 8'h01};
    vecs[3] = '{8'h01, 8'h80, 8'h01, 8'h80};
    vecs[4] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};

    // Reset state.
    idle_pads();
    bus.tx_data = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rx_data",   bus.rx_data,   8'h00);
    check("rst_rx_valid",  bus.rx_valid,  1'b0);
    check("rst_overrun",   bus.overrun,   1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_miso",      bus.spi_miso,  1'b0);
    check("rst_state",     dbg_state,     ST_IDLE);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
    check("ready_after_rst", dbg_state, ST_READY);

    // 1: single word 0xD7 with exact latency.
    fe0 = fe_cnt;
    frame_start();
    check("t1_busy", bus.busy, 1'b1);
    send_word(8'hD7, 8'h00, 1'b1, 1'b0, mw);
    check("t1_rx_data", bus.rx_data, 8'hD7);
    ack_word("t1_ack");
    frame_end();
    check("t1_frame_err", fe_cnt - fe0, 0);

    // Table of single-word frames.
    for (int v = 0; v < 5; v++) begin
      bus.tx_data = vecs[v].tx;
      frame_start();
      send_word(vecs[v].mosi, 8'h00, 1'b0, 1'b0, mw);
      wait_valid("vec_valid");
      check("vec_rx", bus.rx_data, vecs[v].exp_rx);
      check("vec_miso", mw, vecs[v].exp_miso);
      ack_word("vec_ack");
      frame_end();
    end

    // 2: two words in one frame, each acknowledged.
    fe0 = fe_cnt;
    frame_start();
    send_word(8'hA5, 8'h00, 1'b0, 1'b0, mw);
    wait_valid("t2_v1");
    check("t2_w1", bus.rx_data, 8'hA5);
    ack_word("t2_ack1");
    send_word(8'h3C, 8'h00, 1'b0, 1'b0, mw);
    wait_valid("t2_v2");
    check("t2_w2", bus.rx_data, 8'h3C);
    ack_word("t2_ack2");
    frame_end();
    check("t2_overrun", bus.overrun, 1'b0);
    check("t2_busy", bus.busy, 1'b0);
    check("t2_frame_err", fe_cnt - fe0, 0);

    // 3: partial word then deselect.
    fe0 = fe_cnt;
    frame_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1, mb);
    frame_end();
    check("t3_frame_err_width", fe_cnt - fe0, 1);
    check("t3_rx_valid", bus.rx_valid, 1'b0);
    frame_start();
    send_word(8'h81, 8'h00, 1'b0, 1'b0, mw);
    wait_valid("t3_v");
    check("t3_rx", bus.rx_data, 8'h81);
    ack_word("t3_ack");
    frame_end();

    // 4a: overrun.
    do_reset();
    frame_start();
    send_word(8'h11, 8'h00, 1'b0, 1'b0, mw);
    send_word(8'h22, 8'h00, 1'b0, 1'b0, mw);
    frame_end();
    check("t4a_rx", bus.rx_data, 8'h22);
    check("t4a_overrun", bus.overrun, 1'b1);
    check("t4a_valid", bus.rx_valid, 1'b1);
    ack_word("t4a_ack");
    check("t4a_overrun_sticky", bus.overrun, 1'b1);

    // 4b: ack coincident with second word completion.
    do_reset();
    frame_start();
    send_word(8'h11, 8'h00, 1'b0, 1'b0, mw);
    send_word(8'h22, 8'h00, 1'b0, 1'b1, mw);
    frame_end();
    check("t4b_rx", bus.rx_data, 8'h22);
    check("t4b_valid", bus.rx_valid, 1'b1);
    check("t4b_overrun", bus.overrun, 1'b0);
    ack_word("t4b_ack");

    // 5: MISO shifting, reload of next word, idle after deselect.
    bus.tx_data = 8'h5A;
    frame_start();
    send_word(8'h00, 8'hA5, 1'b0, 1'b0, mw);
    check("t5_miso_word", mw, 8'h5A);
    repeat (HALF) @(negedge clk);
    check("t5_miso_reload_msb", bus.spi_miso, 1'b1);
    bus.spi_ss_n = 1'b1;
    repeat (HALF + 2) @(negedge clk);
    check("t5_miso_after_ss", bus.spi_miso, 1'b0);
    ack_word("t5_ack");

    // 6: reset in the middle of a frame.
    frame_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1, mb);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_state", dbg_state, ST_IDLE);
    check("t6_valid", bus.rx_valid, 1'b0);
    check("t6_busy", bus.busy, 1'b0);
    check("t6_miso", bus.spi_miso, 1'b0);
    send_word(8'hFF, 8'h00, 1'b0, 1'b0, mw);
    repeat (HALF) @(negedge clk);
    check("t6_no_word", bus.rx_valid, 1'b0);
    check("t6_still_idle", dbg_state, ST_IDLE);
    frame_end();
    frame_start();
    send_word(8'hC3, 8'h00, 1'b0, 1'b0, mw);
    wait_valid("t6_v");
    check("t6_rx", bus.rx_data, 8'hC3);
    ack_word("t6_ack");
    frame_end();

    // Random multi-word frames against the reference model.
    for (int f = 0; f < 8; f++) begin
      int         nw;
      logic [7:0] rw [3];
      logic [7:0] tw [4];
      nw = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) tw[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 3; k++) begin
        int acc = 0;
        for (int b = 0; b < 8; b++) acc = acc * 2 + $urandom_range(0, 1);
        rw[k] = 8'(acc);
      end
      fe0 = fe_cnt;
      bus.tx_data = tw[0];
      frame_start();
      for (int k = 0; k < nw; k++) begin
        send_word(rw[k], tw[k+1], 1'b0, 1'b0, mw);
        exp_q.push_back(rw[k]);
        wait_valid("rnd_valid");
        check("rnd_rx", bus.rx_data, exp_q.pop_front());
        check("rnd_miso", mw, tw[k]);
        ack_word("rnd_ack");
      end
      frame_end();
      check("rnd_busy", bus.busy, 1'b0);
      check("rnd_frame_err", fe_cnt - fe0, 0);
      check("rnd_overrun", bus.overrun, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
